// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle between the ALU sequencer and its surroundings: the instruction
// stream (s_*), the result stream (m_*) and the shared ALU drive/return.
// The slave modport is the sequencer's view; master is the environment's view
// (instruction source, result consumer and ALU together).
interface alu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  // Instruction stream
  logic             s_valid;
  logic             s_ready;
  logic [2:0]       s_op;
  logic [WIDTH-1:0] s_operand;

  // ALU drive and return
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_neg;

  // Result stream
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_zero;
  logic             m_neg;

  modport slave (
    input  s_valid, s_op, s_operand,
    output s_ready,
    output alu_sel, bus_a, bus_b,
    input  alu_out, alu_zero, alu_neg,
    output m_valid, m_data, m_zero, m_neg,
    input  m_ready
  );

  modport master (
    output s_valid, s_op, s_operand,
    input  s_ready,
    input  alu_sel, bus_a, bus_b,
    output alu_out, alu_zero, alu_neg,
    input  m_valid, m_data, m_zero, m_neg,
    output m_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning the shared signed ALU and its accumulator. Takes one
// instruction at a time, runs it through the ALU for one cycle, captures the
// result and flags, and offers the result on the valid/ready result port.
// All outputs are registered; ALU drive registers are loaded with the value
// they must show in the following state so EXEC sees them from its first cycle.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  alu_seq_ctrl_if.slave    bus,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_HALF = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_SQR  = 3'b111;

  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_SUB  = 3'b010;
  localparam logic [2:0] SEL_MUL  = 3'b011;
  localparam logic [2:0] SEL_HALF = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_exec;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc;
  logic             r_zero;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s_ready;
  logic             r_m_valid;
  logic [2:0]       r_alu_sel;
  logic [WIDTH-1:0] r_bus_a;
  logic [WIDTH-1:0] r_bus_b;

  logic [2:0]       w_op_nxt;
  logic [WIDTH-1:0] w_opnd_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [2:0]       w_sel_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the accept/execute strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (bus.m_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Values the latched instruction and accumulator take after this edge
  always_comb begin
    w_op_nxt   = w_accept ? bus.s_op : r_op;
    w_opnd_nxt = w_accept ? bus.s_operand : r_opnd;
    w_acc_nxt  = w_exec ? bus.alu_out : r_acc;
  end

  // ALU drive for the coming cycle; idles in pass mode on the accumulator
  always_comb begin
    w_sel_nxt = SEL_PASS;
    w_a_nxt   = w_acc_nxt;
    w_b_nxt   = '0;
    if (w_state_nxt == ST_EXEC) begin
      case (w_op_nxt)
        OP_PASS: begin
          w_sel_nxt = SEL_PASS;
        end
        OP_ADD: begin
          w_sel_nxt = SEL_ADD;
          w_b_nxt   = w_opnd_nxt;
        end
        OP_SUB: begin
          w_sel_nxt = SEL_SUB;
          w_b_nxt   = w_opnd_nxt;
        end
        OP_MUL: begin
          w_sel_nxt = SEL_MUL;
          w_b_nxt   = w_opnd_nxt;
        end
        OP_HALF: begin
          w_sel_nxt = SEL_HALF;
        end
        OP_LOAD: begin
          w_a_nxt = w_opnd_nxt;
        end
        OP_CLR: begin
          w_a_nxt = '0;
        end
        OP_SQR: begin
          w_sel_nxt = SEL_MUL;
          w_b_nxt   = w_acc_nxt;
        end
        default: begin
          w_sel_nxt = SEL_PASS;
        end
      endcase
    end
  end

  // Instruction latch, loaded on accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op   <= '0;
      r_opnd <= '0;
    end else if (w_accept) begin
      r_op   <= bus.s_op;
      r_opnd <= bus.s_operand;
    end
  end

  // Accumulator, flags and completed-op counter, captured at the end of EXEC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc  <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_exec) begin
      r_acc  <= bus.alu_out;
      r_zero <= bus.alu_zero;
      r_neg  <= bus.alu_neg;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Registered handshake and ALU drive outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_alu_sel <= SEL_PASS;
      r_bus_a   <= '0;
      r_bus_b   <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_IDLE);
      r_m_valid <= (w_state_nxt == ST_RESP);
      r_alu_sel <= w_sel_nxt;
      r_bus_a   <= w_a_nxt;
      r_bus_b   <= w_b_nxt;
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_acc;
  assign bus.m_zero  = r_zero;
  assign bus.m_neg   = r_neg;
  assign bus.alu_sel = r_alu_sel;
  assign bus.bus_a   = r_bus_a;
  assign bus.bus_b   = r_bus_b;
  assign op_count    = r_cnt;

endmodule
